// File: rtl/pe_flit_tx.sv
// Transmit-side flit injector for one mesh router local port: sends a latched
// number of single-flit packets with a programmable idle gap, honouring backpressure.
module pe_flit_tx #(
  parameter logic [2:0] MY_ID      = 3'd0,
  parameter int         DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_wire,
  input  logic [2:0]            send_num_wire,
  input  logic [3:0]            rate_wire,
  input  logic [23:0]           dst_seq_wire,
  input  logic                  flush_wire,
  input  logic                  full,
  output logic [DATA_WIDTH-1:0] data_p2r,
  output logic                  valid_p2r,
  output logic                  task_send_finish_flag,
  output logic [2:0]            sent_cnt
);

  typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              ts_q;
  logic [2:0]              num_q, num_d;
  logic [3:0]              rate_q, rate_d;
  logic [23:0]             dst_q, dst_d;
  logic [2:0]              idx_q, idx_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [3:0]              gap_q, gap_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    flag_q, flag_d;

  // Flit i's destination lives at dst_seq[3i+2:3i].
  function automatic logic [31:0] mk_flit(input logic [23:0] seq, input logic [2:0] i,
                                          input logic [7:0] ts);
    logic [4:0]  pos;
    logic [23:0] sh;
    pos = {2'b00, i} + {1'b0, i, 1'b0};
    sh  = seq >> pos;
    return {sh[2:0], MY_ID, i, ts, 15'd0};
  endfunction

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rate_d  = rate_q;
    dst_d   = dst_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    data_d  = data_q;
    valid_d = 1'b0;
    flag_d  = 1'b0;
    if (flush_wire) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: if (enable_wire) begin
          num_d  = send_num_wire;
          rate_d = rate_wire;
          dst_d  = dst_seq_wire;
          idx_d  = 3'd0;
          cnt_d  = 3'd0;
          if (send_num_wire == 3'd0) begin
            state_d = DONE;
            flag_d  = 1'b1;
          end else if (rate_wire == 4'd0) begin
            state_d = SEND;
            valid_d = 1'b1;
            data_d  = mk_flit(dst_seq_wire, 3'd0, ts_q);
          end else begin
            state_d = GAP;
            gap_d   = rate_wire;
          end
        end
        GAP: if (gap_q == 4'd1) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = mk_flit(dst_q, idx_q, ts_q);
        end else begin
          gap_d = gap_q - 4'd1;
        end
        SEND: if (full) begin
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_d == num_q) begin
            state_d = DONE;
            flag_d  = 1'b1;
          end else if (rate_q == 4'd0) begin
            valid_d = 1'b1;
            data_d  = mk_flit(dst_q, idx_d, ts_q);
          end else begin
            state_d = GAP;
            gap_d   = rate_q;
          end
        end
        DONE: if (!enable_wire) state_d = IDLE;
              else              flag_d  = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ts_q    <= 8'd0;
      num_q   <= 3'd0;
      rate_q  <= 4'd0;
      dst_q   <= 24'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 3'd0;
      gap_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 8'd1;
      num_q   <= num_d;
      rate_q  <= rate_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
    end
  end

  assign data_p2r              = data_q;
  assign valid_p2r             = valid_q;
  assign task_send_finish_flag = flag_q;
  assign sent_cnt              = cnt_q;

endmodule

// File: tb/tb_pe_flit_tx.sv
// Scoreboard bench for pe_flit_tx: expected flit headers are queued per task and
// popped on every accepted flit; timestamps are checked against a free-running model.
module tb_pe_flit_tx;
  localparam logic [2:0] SRC = 3'd2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b0, flush = 1'b0, full = 1'b0;
  logic [2:0]  send_num = 3'd0;
  logic [3:0]  rate = 4'd0;
  logic [23:0] dst_seq = 24'd0;
  logic [31:0] data_p2r;
  logic        valid_p2r, flag;
  logic [2:0]  sent_cnt;

  int          checks = 0, errors = 0;
  logic [8:0]  sb[$];
  logic [8:0]  exp_hdr;
  logic [7:0]  cyc;
  logic        pv = 1'b0, pacc = 1'b0;
  logic [31:0] pdata = 32'd0;

  always #5 clk = ~clk;

  pe_flit_tx #(.MY_ID(SRC), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable_wire(enable), .send_num_wire(send_num),
    .rate_wire(rate), .dst_seq_wire(dst_seq), .flush_wire(flush), .full(full),
    .data_p2r(data_p2r), .valid_p2r(valid_p2r), .task_send_finish_flag(flag),
    .sent_cnt(sent_cnt)
  );

  // Reference timestamp: cleared by reset, +1 per rising edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 8'd0;
    else        cyc <= cyc + 8'd1;

  // Accept monitor: a flit transfers at the next rising edge when valid && !full.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pacc = 1'b0;
    end else begin
      if (valid_p2r) begin
        checks++;
        if (!pv || pacc) begin
          if (data_p2r[22:15] !== cyc - 8'd1) begin
            errors++; $display("FAIL ts_capture: got %0d want %0d", data_p2r[22:15], cyc - 8'd1);
          end
        end else if (data_p2r !== pdata) begin
          errors++; $display("FAIL stall_hold: got %h want %h", data_p2r, pdata);
        end
        if (!full) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL unexpected_flit: got %h want none", data_p2r);
          end else begin
            exp_hdr = sb.pop_front();
            if (data_p2r[31:23] !== exp_hdr || data_p2r[14:0] !== 15'd0) begin
              errors++; $display("FAIL flit_fields: got %h want hdr %h rsvd 0", data_p2r, exp_hdr);
            end
          end
        end
      end
      pv = valid_p2r; pacc = valid_p2r && !full; pdata = data_p2r;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_flits(input logic [23:0] seq, input int n);
    logic [23:0] s;
    s = seq;
    for (int i = 0; i < n; i++) begin
      sb.push_back({s[2:0], SRC, 3'(i)});
      s = s >> 3;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_p2r !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_p2r); end
    checks++; if (data_p2r !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", data_p2r); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", flag); end
    checks++; if (sent_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", sent_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (valid_p2r !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", valid_p2r); end
  endtask

  task automatic test_basic();
    dst_seq = {15'd0, 3'd5, 3'd1, 3'd7}; send_num = 3'd3; rate = 4'd2; full = 1'b0;
    push_flits(dst_seq, 3);
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (valid_p2r !== 1'(k % 3 == 2)) begin errors++; $display("FAIL basic_valid k=%0d: got %b want %b", k, valid_p2r, k % 3 == 2); end
      checks++; if (sent_cnt !== 3'(k / 3)) begin errors++; $display("FAIL basic_cnt k=%0d: got %0d want %0d", k, sent_cnt, k / 3); end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL basic_early_flag k=%0d: got %b want 0", k, flag); end
    end
    tick();
    checks++; if (flag !== 1'b1 || valid_p2r !== 1'b0) begin errors++; $display("FAIL basic_finish: got flag %b valid %b want 1 0", flag, valid_p2r); end
    checks++; if (sent_cnt !== 3'd3) begin errors++; $display("FAIL basic_final_cnt: got %0d want 3", sent_cnt); end
    enable = 1'b0;
    tick();
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL basic_flag_clear: got %b want 0", flag); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pts;
    pts = 8'd0;
    dst_seq = 24'($urandom()); send_num = 3'd7; rate = 4'd0;
    push_flits(dst_seq, 7);
    enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (valid_p2r !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d: got %b want 1", k, valid_p2r); end
      if (k > 0) begin
        checks++; if (data_p2r[22:15] !== pts + 8'd1) begin errors++; $display("FAIL b2b_ts k=%0d: got %0d want %0d", k, data_p2r[22:15], pts + 8'd1); end
      end
      pts = data_p2r[22:15];
    end
    tick();
    checks++; if (flag !== 1'b1 || valid_p2r !== 1'b0 || sent_cnt !== 3'd7) begin
      errors++; $display("FAIL b2b_finish: got flag %b valid %b cnt %0d want 1 0 7", flag, valid_p2r, sent_cnt);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] hold;
    dst_seq = 24'($urandom()); send_num = 3'd3; rate = 4'd1;
    push_flits(dst_seq, 3);
    enable = 1'b1;
    tick(); tick();
    checks++; if (valid_p2r !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", valid_p2r); end
    tick(); tick();
    checks++; if (valid_p2r !== 1'b1 || sent_cnt !== 3'd1) begin errors++; $display("FAIL bp_flit1: got valid %b cnt %0d want 1 1", valid_p2r, sent_cnt); end
    hold = data_p2r;
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (valid_p2r !== 1'b1 || data_p2r !== hold) begin errors++; $display("FAIL bp_hold k=%0d: got %b %h want 1 %h", k, valid_p2r, data_p2r, hold); end
      checks++; if (sent_cnt !== 3'd1) begin errors++; $display("FAIL bp_cnt k=%0d: got %0d want 1", k, sent_cnt); end
    end
    full = 1'b0;
    tick();
    checks++; if (valid_p2r !== 1'b0 || sent_cnt !== 3'd2) begin errors++; $display("FAIL bp_release: got valid %b cnt %0d want 0 2", valid_p2r, sent_cnt); end
    for (int k = 0; k < 8 && !flag; k++) tick();
    checks++; if (flag !== 1'b1 || sent_cnt !== 3'd3) begin errors++; $display("FAIL bp_finish: got flag %b cnt %0d want 1 3", flag, sent_cnt); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_freeze();
    dst_seq = 24'($urandom()); send_num = 3'd4; rate = 4'd1;
    push_flits(dst_seq, 4);
    enable = 1'b1;
    tick();
    rate = 4'd9; dst_seq = ~dst_seq; send_num = 3'd7;
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (valid_p2r !== 1'(k % 2 == 1)) begin errors++; $display("FAIL freeze_valid k=%0d: got %b want %b", k, valid_p2r, k % 2 == 1); end
    end
    tick();
    checks++; if (flag !== 1'b1 || sent_cnt !== 3'd4) begin errors++; $display("FAIL freeze_finish: got flag %b cnt %0d want 1 4", flag, sent_cnt); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    send_num = 3'd0; rate = 4'($urandom_range(15, 0)); enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (flag !== 1'b1 || valid_p2r !== 1'b0) begin errors++; $display("FAIL zero_done k=%0d: got flag %b valid %b want 1 0", k, flag, valid_p2r); end
    end
    checks++; if (sent_cnt !== 3'd0) begin errors++; $display("FAIL zero_cnt: got %0d want 0", sent_cnt); end
    enable = 1'b0;
    tick();
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL zero_clear: got %b want 0", flag); end
  endtask

  task automatic test_flush();
    dst_seq = 24'($urandom()); send_num = 3'd5; rate = 4'd3;
    push_flits(dst_seq, 5);
    enable = 1'b1;
    for (int k = 0; k < 40 && sent_cnt != 3'd2; k++) tick();
    checks++; if (sent_cnt !== 3'd2 || valid_p2r !== 1'b0) begin errors++; $display("FAIL flush_setup: got cnt %0d valid %b want 2 0", sent_cnt, valid_p2r); end
    flush = 1'b1; enable = 1'b0;
    tick();
    checks++; if (valid_p2r !== 1'b0 || sent_cnt !== 3'd0 || flag !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got valid %b cnt %0d flag %b want 0 0 0", valid_p2r, sent_cnt, flag);
    end
    flush = 1'b0;
    sb.delete();
    dst_seq = 24'($urandom()); send_num = 3'd2; rate = 4'd0;
    push_flits(dst_seq, 2);
    enable = 1'b1;
    tick();
    checks++; if (valid_p2r !== 1'b1 || data_p2r[25:23] !== 3'd0) begin errors++; $display("FAIL flush_restart: got valid %b idx %0d want 1 0", valid_p2r, data_p2r[25:23]); end
    tick(); tick();
    checks++; if (flag !== 1'b1 || sent_cnt !== 3'd2) begin errors++; $display("FAIL flush_refinish: got flag %b cnt %0d want 1 2", flag, sent_cnt); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 300 && cyc != 8'd250; k++) tick();
    dst_seq = 24'($urandom()); send_num = 3'd7; rate = 4'd0;
    push_flits(dst_seq, 7);
    enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (data_p2r[22:15] !== 8'(250 + k)) begin errors++; $display("FAIL wrap_ts k=%0d: got %0d want %0d", k, data_p2r[22:15], 8'(250 + k)); end
    end
    tick();
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL wrap_finish: got %b want 1", flag); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    dst_seq = 24'($urandom()); send_num = 3'd3; rate = 4'd0;
    push_flits(dst_seq, 3);
    enable = 1'b1;
    tick();
    checks++; if (valid_p2r !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", valid_p2r); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid_p2r !== 1'b0 || data_p2r !== 32'd0) begin errors++; $display("FAIL arst_valid: got %b %h want 0 0", valid_p2r, data_p2r); end
    checks++; if (sent_cnt !== 3'd0 || flag !== 1'b0) begin errors++; $display("FAIL arst_state: got cnt %0d flag %b want 0 0", sent_cnt, flag); end
    enable = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (valid_p2r !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b want 0", valid_p2r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_freeze();
    test_zero();
    test_flush();
    test_wrap();
    test_async_reset();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_flit_tx.md
# pe_flit_tx

Transmit-side traffic injector that drives one router local input port of the 2x4 mesh (`data_p2r`, `valid_p2r`) and honours the router's `full` backpressure. When enabled, it emits a configured number of single-flit packets to a configured destination sequence, inserting a programmable idle gap between flits. It raises a sticky completion flag when all flits have been accepted. One instance sits beside each router; the paired receive-side checker consumes the same flit format on the other end of the mesh.

## Interface
- `MY_ID`, 3'd0: source node ID placed in every flit.
- `DATA_WIDTH`, 32: flit width. Only 32 is supported.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable_wire`  in  1: level start request, sampled in IDLE.
- `send_num_wire`  in  3: number of flits to send (0–7). 0 means none.
- `rate_wire`  in  4: idle cycles between flits (0–15).
- `dst_seq_wire`  in  24: destination of flit i is at bits [3i+2:3i].
- `flush_wire`  in  1: synchronous abort and clear.
- `full`  in  1: router local FIFO full; while high, no flit is accepted.
- `data_p2r`  out  32: flit to router.
- `valid_p2r`  out  1: flit valid.
- `task_send_finish_flag`  out  1: all flits accepted.
- `sent_cnt`  out  3: number of flits accepted in the current task.

## Operation
- Flit format:
  - [31:29] dst
  - [28:26] MY_ID
  - [25:23] flit index i
  - [22:15] timestamp
  - [14:0] 15'd0 (reserved)
- Flits with dst == MY_ID are sent normally; the router delivers them locally.
- Timestamp: an 8-bit free-running counter, cleared by reset, +1 every cycle, wraps 255→0. It is captured into the flit at the edge where the block enters SEND.
- Transfer rule: a flit is accepted on a rising edge where `valid_p2r`=1 and `full`=0.
- While `full`=1, `valid_p2r` and `data_p2r` hold unchanged, including the timestamp.
- FSM states: IDLE, GAP, SEND, DONE.
- IDLE:
  - If `enable_wire`=1, latch `send_num_wire`, `rate_wire` and `dst_seq_wire`, and clear idx and `sent_cnt`.
  - If latched send_num=0, go to DONE.
  - Else if latched rate=0, go to SEND with flit 0.
  - Else go to GAP with the gap counter loaded to rate.
- GAP: decrement the gap counter each cycle. When it reaches 1, go to SEND at the next edge. Result: exactly `rate` cycles with `valid_p2r`=0.
- SEND: `valid_p2r`=1. On accept:
  - Increment idx and `sent_cnt`.
  - If the new count equals send_num, go to DONE.
  - Else if rate=0, stay in SEND and present the next flit.
  - Else go to GAP.
- DONE:
  - `task_send_finish_flag`=1, `valid_p2r`=0.
  - Go to IDLE when `enable_wire`=0; the flag clears on that transition.
  - `enable_wire` held high keeps the block in DONE, so there is no automatic restart.
- Latched configuration is frozen for the whole task. Input changes mid-task are ignored.
- Deasserting `enable_wire` mid-task does not abort the task.
- `flush_wire`=1 has highest priority from any state. At the next edge:
  - State → IDLE.
  - `valid_p2r`=0, `sent_cnt`=0, finish flag=0.
  - A pending unaccepted flit is dropped.
  - A flit presented in that same cycle with `full`=0 is still counted as accepted by the router but is not reported.
- Width rules:
  - idx and `sent_cnt` are 3 bits; they never exceed 7 because send_num ≤ 7.
  - The gap counter is 4 bits.

## Timing
- Reset values: `data_p2r`=0, `valid_p2r`=0, `task_send_finish_flag`=0, `sent_cnt`=0, timestamp=0, state IDLE. Reset acts immediately and asynchronously, including mid-flit.
- All outputs are registered. No combinational path from `full` to any output.
- Start latency: with `enable_wire` sampled high at edge E0, the first `valid_p2r` goes high after E0 + rate cycles. With rate=0, it goes high the cycle after E0.
- Inter-flit: after an accept edge, `valid_p2r` is low for exactly rate cycles. With rate=0, flits go back-to-back with valid continuously high.
- Finish: the flag rises the cycle after the last accept edge. `valid_p2r` falls in that same cycle.
- Throughput: best case 1 flit per (rate+1) cycles. Each `full` cycle in SEND adds one cycle.

## Test plan
- Basic send: MY_ID=2, send_num=3, rate=2, dst_seq={…,3'd5,3'd1,3'd7}, full=0.
  - Response: 3 flits with dst 7,1,5, src 2, idx 0,1,2, reserved bits 0.
  - Valid pulses are 1 cycle wide, separated by exactly 2 low cycles.
  - Flag high the cycle after the 3rd accept; sent_cnt=3.
- Back-to-back: rate=0, send_num=7.
  - Response: valid high for 7 consecutive cycles.
  - Timestamps increment by 1 per flit; flag follows immediately.
- Backpressure: full=1 for 5 cycles while flit 1 is presented.
  - Response: data_p2r stable, including timestamp, valid held high.
  - Accept occurs on the first edge with full=0; sent_cnt does not advance while full=1.
- Zero-length and hold: send_num=0 with enable=1.
  - Response: flag=1 one cycle later with no valid pulse.
  - Block stays in DONE while enable=1; with enable=0, the flag clears next cycle.
- Flush mid-task: flush during GAP after 2 of 5 flits.
  - Response: next cycle valid=0, sent_cnt=0, flag=0, state IDLE.
  - Re-enable restarts from flit 0 with newly latched configuration.
- Config freeze, timestamp wrap, and async reset:
  - Change rate and dst_seq mid-task → no effect on the current task.
  - Run across timestamp 255→0 → flit field shows 0 after 255.
  - rst_n low while valid is high → valid drops immediately.
